// File: rtl/broadcast_fork.sv
// Registered one-to-many stream fork: one word is held and offered to every
// lane, and the next word is taken only after each lane has consumed it once.
module broadcast_fork #(
  parameter int OUT_SIZE = 2,
  parameter int IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] data_in,
  input  logic                data_in_valid,
  output logic                data_in_ready,
  output logic [IN_WIDTH-1:0] data_out [OUT_SIZE-1:0],
  output logic [OUT_SIZE-1:0] data_out_valid,
  input  logic [OUT_SIZE-1:0] data_out_ready
);

  logic [IN_WIDTH-1:0] data_q;
  logic                full_q;
  logic [OUT_SIZE-1:0] sent_q;

  logic [OUT_SIZE-1:0] take;
  logic                all_done;
  logic                acc;

  // Lane valids come straight from registers; only data_in_ready sees the
  // lane readies combinationally, so a new word can follow the last take.
  assign data_out_valid = {OUT_SIZE{full_q}} & ~sent_q;
  assign take           = data_out_valid & data_out_ready;
  assign all_done       = full_q & (&(sent_q | take));
  assign data_in_ready  = ~full_q | all_done;
  assign acc            = data_in_valid & data_in_ready;

  for (genvar i = 0; i < OUT_SIZE; i++) begin : g_lane
    assign data_out[i] = data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
      sent_q <= '0;
    end else if (acc) begin
      data_q <= data_in;
      full_q <= 1'b1;
      sent_q <= '0;
    end else if (all_done) begin
      full_q <= 1'b0;
      sent_q <= '0;
    end else begin
      sent_q <= sent_q | take;
    end
  end

endmodule

// File: tb/tb_broadcast_fork.sv
// Bench for broadcast_fork: directed scenarios plus random backpressure, all
// checked every cycle against a word-count model of the fork.
module tb_broadcast_fork;

  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [W-1:0] dout [N-1:0];
  logic [N-1:0] dvalid;
  logic [N-1:0] dready = '0;

  always #5 clk = ~clk;

  broadcast_fork #(.OUT_SIZE(N), .IN_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .data_in       (din),
    .data_in_valid (din_valid),
    .data_in_ready (din_ready),
    .data_out      (dout),
    .data_out_valid(dvalid),
    .data_out_ready(dready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of accepted words and, per lane, how many words it has taken.
  logic [W-1:0] words[$];
  int           nacc = 0;
  int           ntake [N];
  bit           pend_acc = 1'b0;
  logic [N-1:0] pend_take = '0;
  logic [W-1:0] pend_data = '0;

  // Sequence scoreboard for the random phase.
  bit           log_on = 1'b0;
  logic [W-1:0] sent_log[$];
  int           rx_cnt [N];

  initial for (int i = 0; i < N; i++) begin ntake[i] = 0; rx_cnt[i] = 0; end

  function automatic bit exp_ready();
    bit r = 1'b1;
    for (int i = 0; i < N; i++)
      if (!(ntake[i] == nacc || (ntake[i] == nacc - 1 && dready[i]))) r = 1'b0;
    return r;
  endfunction

  function automatic logic [W-1:0] last_word();
    return (nacc > 0) ? words[nacc-1] : '0;
  endfunction

  function automatic bit model_idle();
    bit r = 1'b1;
    for (int i = 0; i < N; i++) if (ntake[i] != nacc) r = 1'b0;
    return r;
  endfunction

  always @(negedge rst_n) begin
    words.delete();
    nacc = 0;
    for (int i = 0; i < N; i++) ntake[i] = 0;
    pend_acc  = 1'b0;
    pend_take = '0;
  end

  // Compare on the falling edge, then latch the handshakes the model expects.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("lane%0d_valid", i), 64'(dvalid[i]), 64'(ntake[i] < nacc));
      check($sformatf("lane%0d_data", i), 64'(dout[i]), 64'(last_word()));
    end
    check("in_ready", 64'(din_ready), 64'(exp_ready()));
    if (rst_n) begin
      for (int i = 0; i < N; i++) pend_take[i] = (ntake[i] < nacc) && dready[i];
      pend_acc  = din_valid && exp_ready();
      pend_data = din;
    end else begin
      pend_take = '0;
      pend_acc  = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (pend_acc && log_on) sent_log.push_back(pend_data);
      for (int i = 0; i < N; i++) begin
        if (pend_take[i]) begin
          if (log_on) begin
            if (rx_cnt[i] < sent_log.size())
              check($sformatf("lane%0d_seq", i), 64'(dout[i]), 64'(sent_log[rx_cnt[i]]));
            else
              check($sformatf("lane%0d_extra", i), 64'(rx_cnt[i]), 64'(sent_log.size() - 1));
            rx_cnt[i]++;
          end
          ntake[i]++;
        end
      end
      if (pend_acc) begin
        words.push_back(pend_data);
        nacc++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    int d;

    // Reset/idle with a word already offered
    #1;
    rst_n     = 1'b0;
    din       = 32'hDEADBEEF;
    din_valid = 1'b1;
    dready    = '0;
    repeat (3) begin
      cyc();
      check("idle_valid", 64'(dvalid), 64'(4'b0000));
      check("idle_ready", 64'(din_ready), 64'(1'b1));
    end
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < N; i++)
      check($sformatf("first_word%0d", i), 64'(dout[i]), 64'(32'hDEADBEEF));
    check("first_valid", 64'(dvalid), 64'(4'b1111));
    din_valid = 1'b0;
    dready    = '1;
    cyc();
    check("first_drained", 64'(dvalid), 64'(4'b0000));

    // Full throughput
    for (int k = 1; k <= 16; k++) begin
      din       = 32'(k);
      din_valid = 1'b1;
      #1;
      check("stream_ready", 64'(din_ready), 64'(1'b1));
      cyc();
      check("stream_data", 64'(dout[k % N]), 64'(k));
      check("stream_valid", 64'(dvalid), 64'(4'b1111));
    end
    din_valid = 1'b0;
    cyc();
    check("stream_drained", 64'(dvalid), 64'(4'b0000));

    // Staggered lanes
    dready    = '0;
    din       = 32'hA5;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      logic [N-1:0] ev;
      case (c)
        1: dready = 4'b0001;
        3: dready = 4'b0110;
        6: dready = 4'b1000;
        default: dready = 4'b0000;
      endcase
      #1;
      check("stag_ready", 64'(din_ready), 64'(c == 6));
      cyc();
      case (c)
        1, 2:    ev = 4'b1110;
        3, 4, 5: ev = 4'b1000;
        default: ev = 4'b0000;
      endcase
      check("stag_valid", 64'(dvalid), 64'(ev));
    end

    // Last take overlapping a new accept
    dready    = 4'b0111;
    din       = 32'h11;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    cyc();
    dready    = 4'b1000;
    din       = 32'h22;
    din_valid = 1'b1;
    #1;
    check("ovl_ready", 64'(din_ready), 64'(1'b1));
    cyc();
    check("ovl_data", 64'(dout[0]), 64'(32'h22));
    check("ovl_valid", 64'(dvalid), 64'(4'b1111));
    din_valid = 1'b0;
    dready    = '1;
    cyc();

    // Asynchronous reset after two lanes took the word
    dready    = 4'b0011;
    din       = 32'h33;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    cyc();
    dready = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_drop", 64'(dvalid), 64'(4'b0000));
    check("rst_ready", 64'(din_ready), 64'(1'b1));
    @(posedge clk);
    #2 rst_n = 1'b1;
    dready = '1;
    repeat (3) begin
      cyc();
      check("rst_no_replay", 64'(dvalid), 64'(4'b0000));
      check("rst_data_zero", 64'(dout[3]), 64'(0));
    end

    // Random words with random per-lane backpressure
    log_on    = 1'b1;
    budget    = 0;
    din_valid = 1'b0;
    while (sent_log.size() < 1000 && budget < 20000) begin
      if (!din_valid || pend_acc) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din       = $urandom;
      end
      dready = N'($urandom);
      cyc();
      budget++;
    end
    din_valid = 1'b0;
    check("rand_budget", 64'(budget < 20000), 64'(1'b1));
    check("rand_count", 64'(sent_log.size()), 64'(1000));
    dready = '1;
    d = 0;
    while (!model_idle() && d < 50) begin
      cyc();
      d++;
    end
    cyc();
    check("rand_drain", 64'(model_idle()), 64'(1'b1));
    for (int i = 0; i < N; i++)
      check($sformatf("lane%0d_total", i), 64'(rx_cnt[i]), 64'(sent_log.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/broadcast_fork.md
# broadcast_fork

Registered one-to-many stream fork: accepts one IN_WIDTH word per handshake and presents it to OUT_SIZE independent consumer lanes. Each lane has its own valid/ready pair and may take the word in a different cycle. The next input word is accepted only once every lane has taken the current one. It is the fan-out counterpart of the pipelined OR/reduction trees in the mxint operators: it distributes a block-shared value (e.g. shared exponent or shift amount) back to per-element datapaths.

## Interface
- OUT_SIZE, 2: number of output lanes (>= 1).
- IN_WIDTH, 32: data word width.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  IN_WIDTH  word to broadcast.
- data_in_valid  input  1  upstream valid.
- data_in_ready  output  1  upstream ready.
- data_out  output  [IN_WIDTH-1:0] x [OUT_SIZE-1:0] (unpacked)  per-lane copy of the held word.
- data_out_valid  output  [OUT_SIZE-1:0]  per-lane valid.
- data_out_ready  input  [OUT_SIZE-1:0]  per-lane ready.

## Operation
- State:
  - data_q: IN_WIDTH holding register.
  - full_q: 1 bit, holding register occupied.
  - sent_q: OUT_SIZE bits, lane i has already taken data_q.
- Outputs:
  - data_out[i] = data_q for every lane.
  - data_out_valid[i] = full_q & ~sent_q[i].
- Lane handshake: take[i] = data_out_valid[i] & data_out_ready[i].
- all_done = full_q & &(sent_q | take). The current word is finished this cycle.
- data_in_ready = ~full_q | all_done.
- Input accept: acc = data_in_valid & data_in_ready. On acc:
  - data_q <= data_in.
  - full_q <= 1.
  - sent_q <= 0.
- all_done without acc: full_q <= 0, sent_q <= 0. data_q holds its value.
- Otherwise: sent_q <= sent_q | take.
- Word is passed unmodified; no width conversion or arithmetic.
- OUT_SIZE = 1 degenerates to a single full-throughput pipeline register.

## Timing
- Reset (rst = 0, asynchronous):
  - data_q = 0, full_q = 0, sent_q = 0.
  - So data_out = 0 on all lanes, data_out_valid = 0, data_in_ready = 1.
  - Reset mid-transfer discards the held word. Lanes that have not yet taken it never see it.
- Latency: word accepted at edge N is visible on all lanes with valid = 1 in cycle N+1.
- Throughput: one word per cycle while all data_out_ready = 1.
- Each lane sees valid for a word exactly until it takes it. A lane never receives the same word twice.
- A lane that took early sees valid = 0 until the next word arrives.
- data_out_valid depends only on registers: no combinational path from data_out_ready or data_in_valid.
- data_in_ready depends combinationally on data_out_ready through all_done (a documented feedthrough).
- data_out_ready may be high before valid; that has no effect.
- Consumers must not drop valid-dependent commitments. The protocol is standard AXI-stream style: the producer holds data_in stable while data_in_valid is high and not accepted.
- Simultaneous events:
  - The last lane's take and a new input accept in the same cycle: the new word replaces data_q and sent_q clears. No bubble.
  - Several lanes taking in the same cycle are all recorded.
  - All lanes taking in the same cycle as full_q first goes high is a full single-cycle transfer.

## Test plan
- Reset/idle: hold rst = 0 with data_in_valid = 1 and data_in = 0xDEADBEEF.
  - Required: data_out_valid = 0 and data_in_ready = 1 throughout.
  - After release, the first edge accepts; next cycle all lanes show 0xDEADBEEF with valid = 1.
- Full throughput, OUT_SIZE = 4, all ready = 1: stream 0x1..0x10 back-to-back.
  - Required: each lane receives 0x1..0x10 in order, one per cycle, 1-cycle latency, and data_in_ready is never low.
- Staggered lanes, OUT_SIZE = 4: send 0xA5. Lane 0 is ready at cycle 1, lanes 1–2 at cycle 3, lane 3 at cycle 6.
  - Required: data_in_ready stays 0 for cycles 1–5 and is 1 in cycle 6.
  - Lane 0 valid drops after cycle 1; lanes 1–2 valid drop after cycle 3.
  - Each lane takes 0xA5 exactly once.
- Overlap: the last lane takes word 0x11 in the same cycle a new word 0x22 is offered.
  - Required: 0x22 is accepted that edge and all lanes show 0x22 with valid = 1 the next cycle.
- Reset mid-transfer: after 2 of 4 lanes have taken 0x33, pulse rst low asynchronously (not edge-aligned).
  - Required: all valids drop to 0 immediately.
  - After release, 0x33 never reappears.
- Random backpressure: 1000 random words with random per-lane ready.
  - Required: every lane's received sequence equals the input sequence, with no duplicates or losses.
